// File: rtl/serial_alu_exec_pkg.sv
// serial_alu_exec_pkg
//   Shared definitions for the serial execute-stage ALU. The ALUControl
//   encodings live here only. The ALU controller imports them from this
//   package as well, so the two sides cannot drift apart.
//   Contents:
//     alu_op_e     - ALUControl op codes (3'b111 is deliberately unassigned)
//     state_e      - sequencing FSM states
//     op_dec_t     - decoded op plus illegal flag
//     decode_ctrl  - maps a raw 3-bit ALUControl onto op_dec_t
//     uses_sub     - ops that run A + ~B + 1 through the slice adder
package serial_alu_exec_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_MIN = 3'b110
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIN,
    ST_DONE
  } state_e;

  typedef struct packed {
    alu_op_e op;
    logic    illegal;
  } op_dec_t;

  // Anything that is not a listed op falls to the default branch and is
  // flagged illegal. This covers 3'b111, and in 4-state simulation it also
  // covers any code containing X or Z bits.
  function automatic op_dec_t decode_ctrl(input logic [2:0] ctrl);
    op_dec_t d;
    d.op      = ALU_ADD;
    d.illegal = 1'b0;
    case (ctrl)
      ALU_ADD: d.op = ALU_ADD;
      ALU_SUB: d.op = ALU_SUB;
      ALU_AND: d.op = ALU_AND;
      ALU_OR:  d.op = ALU_OR;
      ALU_XOR: d.op = ALU_XOR;
      ALU_SLT: d.op = ALU_SLT;
      ALU_MIN: d.op = ALU_MIN;
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  // SLT and MIN both need the difference A - B to find the sign.
  function automatic logic uses_sub(input alu_op_e op);
    return (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_MIN);
  endfunction

endpackage

// File: rtl/serial_alu_exec_if.sv
// serial_alu_exec_if
//   Handshake and data bundle between the datapath/control FSM and the
//   serial ALU.
//   Request side  : in_valid, in_ready, alu_ctrl, a, b
//   Response side : out_valid, out_ready, result, zero, err
//   modport master : the datapath. It drives requests and consumes results.
//   modport slave  : the ALU.
interface serial_alu_exec_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             err;

  modport master (
    output in_valid, alu_ctrl, a, b, out_ready,
    input  in_ready, out_valid, result, zero, err
  );

  modport slave (
    input  in_valid, alu_ctrl, a, b, out_ready,
    output in_ready, out_valid, result, zero, err
  );
endinterface

// File: rtl/serial_alu_exec_alu_slice.sv
// serial_alu_exec_alu_slice
//   Combinational SLICE-wide ALU slice. The top instantiates it once and
//   time-multiplexes it across the operand slices.
//   Ports:
//     op   in  alu_op_e   latched operation
//     a_s  in  SLICE      operand A slice
//     b_s  in  SLICE      operand B slice
//     cin  in  1          carry in from the previous (lower) slice
//     r_s  out SLICE      slice result
//     cout out 1          carry out to the next slice
module serial_alu_exec_alu_slice
  import serial_alu_exec_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  alu_op_e          op,
  input  logic [SLICE-1:0] a_s,
  input  logic [SLICE-1:0] b_s,
  input  logic             cin,
  output logic [SLICE-1:0] r_s,
  output logic             cout
);

  logic [SLICE-1:0] b_eff;
  logic [SLICE-1:0] and_s;
  logic [SLICE-1:0] or_s;
  logic [SLICE-1:0] xor_s;
  logic [SLICE:0]   sum;

  for (genvar gi = 0; gi < SLICE; gi++) begin : g_bit
    assign and_s[gi] = a_s[gi] & b_s[gi];
    assign or_s[gi]  = a_s[gi] | b_s[gi];
    assign xor_s[gi] = a_s[gi] ^ b_s[gi];
  end

  // Subtraction-type ops invert B. The +1 arrives as the carry into slice 0.
  assign b_eff = uses_sub(op) ? ~b_s : b_s;
  assign sum   = {1'b0, a_s} + {1'b0, b_eff} + {{SLICE{1'b0}}, cin};
  assign cout  = sum[SLICE];

  always_comb begin
    r_s = sum[SLICE-1:0];
    case (op)
      ALU_AND: r_s = and_s;
      ALU_OR:  r_s = or_s;
      ALU_XOR: r_s = xor_s;
      default: r_s = sum[SLICE-1:0];
    endcase
  end

endmodule

// File: rtl/serial_alu_exec.sv
// serial_alu_exec
//   Execute-stage ALU that works through the operands SLICE bits at a time.
//   It takes N = WIDTH/SLICE RUN cycles, then one FIN cycle for SLT, MIN and
//   the flags. WIDTH must be an integer multiple of SLICE.
//   Ports:
//     clk  in  clock, rising edge
//     rst  in  synchronous active-high reset
//     bus  serial_alu_exec_if.slave
//          request  : in_valid, in_ready, alu_ctrl, a, b
//          response : out_valid, out_ready, result, zero, err
//   Latency: accept at edge k gives out_valid after edge k+N+1 for every op.
module serial_alu_exec
  import serial_alu_exec_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input logic               clk,
  input logic               rst,
  serial_alu_exec_if.slave  bus
);

  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  alu_op_e          op_q, op_d;
  logic             illegal_q, illegal_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic             in_ready;
  logic             accept;
  logic             handoff;
  logic             last_slice;
  op_dec_t          dec;
  logic             lt;
  logic [SLICE-1:0] a_s, b_s, r_s;
  logic             cout;
  logic [WIDTH-1:0] acc_run;

  assign dec        = decode_ctrl(bus.alu_ctrl);
  assign last_slice = (cnt_q == CNT_W'(N - 1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.in_valid)  state_d = ST_RUN;
      ST_RUN:  if (last_slice)    state_d = ST_FIN;
      ST_FIN:                     state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready = 1'b0;
    accept   = 1'b0;
    handoff  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        accept   = bus.in_valid;
      end
      ST_DONE: handoff = bus.out_ready;
      default: ;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.err       = err_q;

  // ---------------- slice datapath ----------------
  assign a_s = a_q[cnt_q*SLICE +: SLICE];
  assign b_s = b_q[cnt_q*SLICE +: SLICE];

  serial_alu_exec_alu_slice #(
    .SLICE (SLICE)
  ) u_alu_slice (
    .op   (op_q),
    .a_s  (a_s),
    .b_s  (b_s),
    .cin  (carry_q),
    .r_s  (r_s),
    .cout (cout)
  );

  // Only the slice selected by cnt picks up the new slice result. All other
  // slices keep what they already hold.
  for (genvar gi = 0; gi < N; gi++) begin : g_acc
    assign acc_run[gi*SLICE +: SLICE] =
      (cnt_q == CNT_W'(gi)) ? r_s : acc_q[gi*SLICE +: SLICE];
  end

  // If the signs differ, A is smaller exactly when it is negative. If the
  // signs match, the subtraction cannot overflow, so the sign of the
  // difference gives the answer.
  assign lt = (a_q[WIDTH-1] != b_q[WIDTH-1]) ? a_q[WIDTH-1] : acc_q[WIDTH-1];

  always_comb begin
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    op_d        = op_q;
    illegal_d   = illegal_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d       = bus.a;
          b_d       = bus.b;
          op_d      = dec.op;
          illegal_d = dec.illegal;
          cnt_d     = '0;
          carry_d   = uses_sub(dec.op);
          acc_d     = '0;
        end
      end
      ST_RUN: begin
        acc_d   = acc_run;
        carry_d = cout;
        cnt_d   = last_slice ? '0 : cnt_q + 1'b1;
      end
      ST_FIN: begin
        if (illegal_q) begin
          result_d = '0;
          err_d    = 1'b1;
        end else begin
          err_d = 1'b0;
          case (op_q)
            ALU_SLT: result_d = {{(WIDTH-1){1'b0}}, lt};
            ALU_MIN: result_d = lt ? a_q : b_q;
            default: result_d = acc_q;
          endcase
        end
        zero_d      = (result_d == '0);
        out_valid_d = 1'b1;
      end
      ST_DONE: begin
        if (handoff) out_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      op_q        <= ALU_ADD;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      op_q        <= op_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_serial_alu_exec.sv
// tb_serial_alu_exec
//   Directed-vector bench for serial_alu_exec with WIDTH=32 and SLICE=8.
module tb_serial_alu_exec;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_alu_exec_if #(.WIDTH(32)) bus ();

  serial_alu_exec #(
    .WIDTH (32),
    .SLICE (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs === exp) checks_passed++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation end to end. hold = the number of cycles that
  // out_ready stays low after out_valid, with a competing request on in_valid.
  task automatic run_op(input string name, input logic [2:0] ctrl,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_zero,
                        input logic exp_err, input int hold);
    int cycles;
    check({name, " in_ready_idle"}, {31'b0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.alu_ctrl = ctrl;
    bus.a        = a;
    bus.b        = b;
    tick();                       // accept edge
    bus.in_valid = 1'b0;
    bus.alu_ctrl = 3'b000;        // operands must already be latched
    bus.a        = ~a;
    bus.b        = ~b;
    check({name, " in_ready_busy"}, {31'b0, bus.in_ready}, 32'd0);
    cycles = 0;
    while (bus.out_valid !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
    check({name, " latency"}, cycles, 32'd5);
    check({name, " result"}, bus.result, exp_res);
    check({name, " zero"}, {31'b0, bus.zero}, {31'b0, exp_zero});
    check({name, " err"}, {31'b0, bus.err}, {31'b0, exp_err});
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.alu_ctrl = 3'b000;
      bus.a        = 32'h11;
      bus.b        = 32'h22;
      tick();
      check({name, " hold_valid"}, {31'b0, bus.out_valid}, 32'd1);
      check({name, " hold_result"}, bus.result, exp_res);
      check({name, " hold_flags"}, {30'b0, bus.zero, bus.err}, {30'b0, exp_zero, exp_err});
      check({name, " hold_in_ready"}, {31'b0, bus.in_ready}, 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();                       // handoff edge
    bus.out_ready = 1'b0;
    check({name, " valid_drop"}, {31'b0, bus.out_valid}, 32'd0);
    check({name, " back_idle"}, {31'b0, bus.in_ready}, 32'd1);
    check({name, " result_kept"}, bus.result, exp_res);
    $display("op %-8s ctrl=%03b a=%08h b=%08h -> result=%08h zero=%0b err=%0b latency=%0d hold=%0d",
             name, ctrl, a, b, bus.result, bus.zero, bus.err, cycles, hold);
  endtask

  initial begin
    int stray;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.alu_ctrl  = 3'b000;
    bus.a         = '0;
    bus.b         = '0;
    rst           = 1'b1;
    tick();
    tick();
    check("reset in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("reset result", bus.result, 32'd0);
    check("reset flags", {30'b0, bus.zero, bus.err}, 32'd0);
    $display("reset released: in_ready=%0b out_valid=%0b result=%08h", bus.in_ready, bus.out_valid, bus.result);
    rst = 1'b0;
    tick();

    run_op("ADD",      3'b000, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0, 0);
    run_op("ADDWRAP",  3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 0);
    run_op("SUBEQ",    3'b001, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, 0);
    run_op("SUBBRW",   3'b001, 32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0, 1'b0, 0);
    run_op("SLT",      3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 0);
    run_op("SLTSWAP",  3'b101, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0);
    run_op("SLTEDGE",  3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
    run_op("MIN",      3'b110, 32'h0000_0005, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 1'b0, 1'b0, 0);
    run_op("AND",      3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 0);
    run_op("OR",       3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0, 0);
    run_op("MINHOLD",  3'b110, 32'h0000_0007, 32'h0000_0009, 32'h0000_0007, 1'b0, 1'b0, 3);
    run_op("XOR",      3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0, 0);

    // Reset partway through RUN, with cnt at 2.
    bus.in_valid = 1'b1;
    bus.alu_ctrl = 3'b001;
    bus.a        = 32'h0000_0064;
    bus.b        = 32'h0000_0001;
    tick();                       // accept
    bus.in_valid = 1'b0;
    tick();                       // cnt 0 -> 1
    tick();                       // cnt 1 -> 2
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrun in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("midrun out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("midrun result", bus.result, 32'd0);
    check("midrun flags", {30'b0, bus.zero, bus.err}, 32'd0);
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.out_valid === 1'b1) stray++;
    end
    check("midrun no_result", stray, 32'd0);
    $display("reset mid-RUN: in_ready=%0b out_valid=%0b result=%08h stray_valid=%0d",
             bus.in_ready, bus.out_valid, bus.result, stray);

    run_op("ILLEGAL",  3'b111, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 0);
    run_op("ADDAFTER", 3'b000, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
